oflow_score_board_resp: RTL and testbench

- Responder end of the registration-to-score-board handshake.
- Accepts a per-set `start_score_board` pulse carrying the set row and first-frame ID base. For frame 0 it writes sequential new IDs. For later frames it consumes the serial candidate stream from score calc and keeps the minimum score per PE.
- Writes one entry per PE into the score-board row, then returns a single-cycle `done_score_board`.
- Sits between the registration FSM, score calc and the score-board memory.

---
 rtl/oflow_score_board_pkg.sv | 50 +++++
 rtl/oflow_score_min_tracker.sv | 41 ++++
 rtl/oflow_score_board_resp.sv | 153 +++++++++++++++
 tb/tb_oflow_score_board_resp.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_score_board_pkg.sv
// Shared types and constants for the score-board responder.
//   state_t     : responder FSM states
//   SCORE_ONES  : "no candidate yet" score value
//   wr_entry_t  : one score-board write {row, col, id, score, match}
//   make_entry  : builds a wr_entry_t from its fields
package oflow_score_board_pkg;

  localparam int PE_NUM    = 8;
  localparam int ROW_LEN   = 4;
  localparam int ID_LEN    = 12;
  localparam int SCORE_LEN = 16;
  localparam int FRAME_W   = 16;
  localparam int COL_W     = $clog2(PE_NUM);

  localparam logic [SCORE_LEN-1:0] SCORE_THRESH = 16'h0400;
  localparam logic [SCORE_LEN-1:0] SCORE_ONES   = '1;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  typedef struct packed {
    logic [ROW_LEN-1:0]   row;
    logic [COL_W-1:0]     col;
    logic [ID_LEN-1:0]    id;
    logic [SCORE_LEN-1:0] score;
    logic                 match;
  } wr_entry_t;

  function automatic wr_entry_t make_entry(
    input logic [ROW_LEN-1:0]   row,
    input logic [COL_W-1:0]     col,
    input logic [ID_LEN-1:0]    id,
    input logic [SCORE_LEN-1:0] score,
    input logic                 match
  );
    wr_entry_t e;
    e.row   = row;
    e.col   = col;
    e.id    = id;
    e.score = score;
    e.match = match;
    return e;
  endfunction

endpackage

// File: rtl/oflow_score_min_tracker.sv
// Running minimum of candidate scores for one PE.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   clear          : return best to (all-ones, id 0) on the next edge
//   upd            : a candidate is handshaken this cycle
//   cand_score/id  : the candidate
//   fin_score/id   : best including this cycle's candidate (bypass), so the
//                    last candidate of a PE is already reflected in the write
module oflow_score_min_tracker
  import oflow_score_board_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 upd,
  input  logic [SCORE_LEN-1:0] cand_score,
  input  logic [ID_LEN-1:0]    cand_id,
  output logic [SCORE_LEN-1:0] fin_score,
  output logic [ID_LEN-1:0]    fin_id
);

  logic [SCORE_LEN-1:0] best_score;
  logic [ID_LEN-1:0]    best_id;
  logic                 take;

  // Strict compare: on a tie the earlier candidate is kept.
  assign take      = upd && (cand_score < best_score);
  assign fin_score = take ? cand_score : best_score;
  assign fin_id    = take ? cand_id    : best_id;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      best_score <= SCORE_ONES;
      best_id    <= '0;
    end else if (take) begin
      best_score <= cand_score;
      best_id    <= cand_id;
    end
  end

endmodule

// File: rtl/oflow_score_board_resp.sv
// Responder end of the registration-to-score-board handshake.
// On start, frame 0 writes sequential new IDs to every PE column of the
// selected row; later frames consume the serial candidate stream and write
// the minimum-score candidate per PE (or a no-match entry above threshold).
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   start_score_board               : one-cycle request (ignored unless idle)
//   frame_num, row_sel_by_set,
//   id_first_frame                  : request fields, sampled only at start
//   cand_valid/ready/score/id/last  : candidate stream from score calc
//   sb_wr_*                         : registered score-board write port
//   done_score_board                : one-cycle completion pulse
//   busy                            : high from cycle after start to done
module oflow_score_board_resp
  import oflow_score_board_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_score_board,
  input  logic [FRAME_W-1:0]   frame_num,
  input  logic [ROW_LEN-1:0]   row_sel_by_set,
  input  logic [ID_LEN-1:0]    id_first_frame,
  input  logic                 cand_valid,
  output logic                 cand_ready,
  input  logic [SCORE_LEN-1:0] cand_score,
  input  logic [ID_LEN-1:0]    cand_id,
  input  logic                 cand_last,
  output logic                 sb_wr_en,
  output logic [ROW_LEN-1:0]   sb_wr_row,
  output logic [COL_W-1:0]     sb_wr_col,
  output logic [ID_LEN-1:0]    sb_wr_id,
  output logic [SCORE_LEN-1:0] sb_wr_score,
  output logic                 sb_wr_match,
  output logic                 done_score_board,
  output logic                 busy
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(PE_NUM - 1);

  state_t               state;
  logic [ROW_LEN-1:0]   row_q;
  logic [ID_LEN-1:0]    id_base_q;
  logic [COL_W-1:0]     pe_cnt;
  logic [COL_W-1:0]     next_col;
  wr_entry_t            wr_q;
  logic                 hs;
  logic                 match_now;
  logic [SCORE_LEN-1:0] fin_score;
  logic [ID_LEN-1:0]    fin_id;

  assign hs        = cand_valid && cand_ready;
  assign next_col  = pe_cnt + 1'b1;
  assign match_now = (fin_score <= SCORE_THRESH);

  // Best is held only while collecting; any other state leaves it cleared
  // so each PE starts from (all-ones, id 0).
  oflow_score_min_tracker u_min (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != COLLECT),
    .upd        (hs),
    .cand_score (cand_score),
    .cand_id    (cand_id),
    .fin_score  (fin_score),
    .fin_id     (fin_id)
  );

  assign sb_wr_row   = wr_q.row;
  assign sb_wr_col   = wr_q.col;
  assign sb_wr_id    = wr_q.id;
  assign sb_wr_score = wr_q.score;
  assign sb_wr_match = wr_q.match;

  // Outputs are registered for the state being entered, so the write for a
  // FIRST/WRITE cycle is loaded on the edge that enters that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      row_q            <= '0;
      id_base_q        <= '0;
      pe_cnt           <= '0;
      wr_q             <= '0;
      sb_wr_en         <= 1'b0;
      cand_ready       <= 1'b0;
      done_score_board <= 1'b0;
      busy             <= 1'b0;
    end else begin
      wr_q             <= '0;
      sb_wr_en         <= 1'b0;
      done_score_board <= 1'b0;
      case (state)
        IDLE: begin
          if (start_score_board) begin
            row_q     <= row_sel_by_set;
            id_base_q <= id_first_frame;
            pe_cnt    <= '0;
            busy      <= 1'b1;
            if (frame_num == '0) begin
              state    <= FIRST;
              sb_wr_en <= 1'b1;
              wr_q     <= make_entry(row_sel_by_set, '0, id_first_frame, '0, 1'b1);
            end else begin
              state      <= COLLECT;
              cand_ready <= 1'b1;
            end
          end
        end
        FIRST: begin
          if (pe_cnt == LAST_COL) begin
            state            <= DONE;
            done_score_board <= 1'b1;
          end else begin
            pe_cnt   <= next_col;
            sb_wr_en <= 1'b1;
            wr_q     <= make_entry(row_q, next_col, id_base_q + ID_LEN'(next_col),
                                   '0, 1'b1);
          end
        end
        COLLECT: begin
          if (hs && cand_last) begin
            state      <= WRITE;
            cand_ready <= 1'b0;
            sb_wr_en   <= 1'b1;
            wr_q       <= make_entry(row_q, pe_cnt, match_now ? fin_id : '0,
                                     fin_score, match_now);
          end
        end
        WRITE: begin
          if (pe_cnt == LAST_COL) begin
            state            <= DONE;
            done_score_board <= 1'b1;
          end else begin
            pe_cnt     <= next_col;
            state      <= COLLECT;
            cand_ready <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          pe_cnt <= '0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          cand_ready <= 1'b0;
          pe_cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oflow_score_board_resp.sv
// Testbench for oflow_score_board_resp: frame-0 vector table with cycle-exact
// checks, directed and randomized later-frame sets against a per-PE minimum
// reference model, start-while-busy and reset-abort sequences.
module tb_oflow_score_board_resp;
  import oflow_score_board_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start_score_board;
  logic [FRAME_W-1:0]   frame_num;
  logic [ROW_LEN-1:0]   row_sel_by_set;
  logic [ID_LEN-1:0]    id_first_frame;
  logic                 cand_valid;
  logic                 cand_ready;
  logic [SCORE_LEN-1:0] cand_score;
  logic [ID_LEN-1:0]    cand_id;
  logic                 cand_last;
  logic                 sb_wr_en;
  logic [ROW_LEN-1:0]   sb_wr_row;
  logic [COL_W-1:0]     sb_wr_col;
  logic [ID_LEN-1:0]    sb_wr_id;
  logic [SCORE_LEN-1:0] sb_wr_score;
  logic                 sb_wr_match;
  logic                 done_score_board;
  logic                 busy;

  always #5 clk = ~clk;

  oflow_score_board_resp dut (
    .clk               (clk),
    .reset             (reset),
    .start_score_board (start_score_board),
    .frame_num         (frame_num),
    .row_sel_by_set    (row_sel_by_set),
    .id_first_frame    (id_first_frame),
    .cand_valid        (cand_valid),
    .cand_ready        (cand_ready),
    .cand_score        (cand_score),
    .cand_id           (cand_id),
    .cand_last         (cand_last),
    .sb_wr_en          (sb_wr_en),
    .sb_wr_row         (sb_wr_row),
    .sb_wr_col         (sb_wr_col),
    .sb_wr_id          (sb_wr_id),
    .sb_wr_score       (sb_wr_score),
    .sb_wr_match       (sb_wr_match),
    .done_score_board  (done_score_board),
    .busy              (busy)
  );

  int total  = 0;
  int passed = 0;

  // Monitor state (written only by the monitor process)
  wr_entry_t mon_q[$];
  int        done_cnt = 0;
  int        viol     = 0;

  // Candidate plan for one set: per PE a list of (score, id)
  int unsigned          n_c [PE_NUM];
  logic [SCORE_LEN-1:0] c_s [PE_NUM][4];
  logic [ID_LEN-1:0]    c_i [PE_NUM][4];

  typedef struct {
    logic [ROW_LEN-1:0]        row;
    logic [ID_LEN-1:0]         base;
    logic [7:0][ID_LEN-1:0]    ids;
  } f0_vec_t;
  f0_vec_t f0_tbl [3];

  function automatic wr_entry_t cur_entry();
    return make_entry(sb_wr_row, sb_wr_col, sb_wr_id, sb_wr_score, sb_wr_match);
  endfunction

  always @(negedge clk) begin
    if (sb_wr_en === 1'b1) mon_q.push_back(cur_entry());
    if (done_score_board === 1'b1) done_cnt++;
    if (sb_wr_en === 1'b0 && cur_entry() != '0) viol++;
    if (cand_ready === 1'b1 && (sb_wr_en || done_score_board || !busy)) viol++;
  end

  task automatic check_int(input string name, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_wr(input string name, input int idx, input logic en,
                          input wr_entry_t got, input wr_entry_t exp);
    total++;
    if (en === 1'b1 && got === exp) passed++;
    else $display("FAIL %s[%0d]: got en=%0b row=%0d col=%0d id=%0d score=%h match=%0b expected en=1 row=%0d col=%0d id=%0d score=%h match=%0b",
                  name, idx, en, got.row, got.col, got.id, got.score, got.match,
                  exp.row, exp.col, exp.id, exp.score, exp.match);
  endtask

  // Reference: per PE, the lowest score wins, earliest on ties; a best above
  // threshold (or no better-than-all-ones candidate) is reported as no match.
  function automatic wr_entry_t model_entry(input logic [ROW_LEN-1:0] row, input int p);
    logic [SCORE_LEN-1:0] best = SCORE_ONES;
    logic [ID_LEN-1:0]    bid  = '0;
    wr_entry_t            e;
    for (int j = 0; j < int'(n_c[p]); j++)
      if (c_s[p][j] < best) begin
        best = c_s[p][j];
        bid  = c_i[p][j];
      end
    e.row   = row;
    e.col   = COL_W'(p);
    e.score = best;
    e.match = (best <= SCORE_THRESH);
    e.id    = e.match ? bid : '0;
    return e;
  endfunction

  task automatic pulse_start();
    start_score_board = 1'b1;
    @(posedge clk); #1;
    start_score_board = 1'b0;
  endtask

  task automatic send_cand(input logic [SCORE_LEN-1:0] s, input logic [ID_LEN-1:0] id,
                           input logic last);
    bit ok = 0;
    cand_valid = 1'b1;
    cand_score = s;
    cand_id    = id;
    cand_last  = last;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (cand_ready) ok = 1;
      @(posedge clk); #1;
    end
    cand_valid = 1'b0;
    cand_score = SCORE_LEN'($urandom);
    cand_last  = 1'b0;
    if (!ok) check_int("cand_handshake_timeout", 0, 1);
  endtask

  task automatic feed_pes(input int first, input int count, input bit gaps,
                          input int start_at_pe);
    for (int p = first; p < first + count; p++) begin
      if (p == start_at_pe) begin
        // Start while busy, frame 0 and a different row: must be ignored.
        frame_num      = '0;
        row_sel_by_set = ~row_sel_by_set;
        pulse_start();
      end
      for (int j = 0; j < int'(n_c[p]); j++) begin
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send_cand(c_s[p][j], c_i[p][j], j == int'(n_c[p]) - 1);
      end
    end
  endtask

  function automatic logic [SCORE_LEN-1:0] pick_score();
    int r = $urandom_range(0, 9);
    if (r == 0) return SCORE_ONES;
    if (r == 1) return SCORE_THRESH;
    if (r == 2) return SCORE_THRESH + 1'b1;
    return SCORE_LEN'($urandom_range(0, 16'h0500));
  endfunction

  task automatic fill_random();
    for (int p = 0; p < PE_NUM; p++) begin
      n_c[p] = $urandom_range(1, 4);
      for (int j = 0; j < 4; j++) begin
        c_s[p][j] = (j > 0 && $urandom_range(0, 3) == 0) ? c_s[p][j-1] : pick_score();
        c_i[p][j] = ID_LEN'($urandom_range(0, 4095));
      end
    end
  endtask

  task automatic fill_pattern();
    for (int p = 0; p < PE_NUM; p++) begin
      n_c[p] = 3;
      c_s[p][0] = 16'h0300; c_i[p][0] = 12'd4;
      c_s[p][1] = 16'h0100; c_i[p][1] = 12'd9;
      c_s[p][2] = 16'h0100; c_i[p][2] = 12'd2;
    end
  endtask

  task automatic run_collect(input string name, input logic [ROW_LEN-1:0] row,
                             input bit gaps, input int start_at_pe);
    int wbase = mon_q.size();
    int dbase = done_cnt;
    frame_num      = FRAME_W'($urandom_range(1, 65535));
    row_sel_by_set = row;
    id_first_frame = ID_LEN'($urandom);
    pulse_start();
    row_sel_by_set = row + 4'd5;
    frame_num      = '0;
    feed_pes(0, PE_NUM, gaps, start_at_pe);
    repeat (6) begin @(posedge clk); #1; end
    check_int({name, "_n_writes"}, mon_q.size() - wbase, PE_NUM);
    for (int k = 0; k < PE_NUM && wbase + k < mon_q.size(); k++)
      check_wr(name, k, 1'b1, mon_q[wbase + k], model_entry(row, k));
    check_int({name, "_done_count"}, done_cnt - dbase, 1);
    check_int({name, "_busy_after"}, busy, 0);
  endtask

  task automatic run_first(input f0_vec_t v);
    wr_entry_t exp;
    frame_num      = '0;
    row_sel_by_set = v.row;
    id_first_frame = v.base;
    pulse_start();
    row_sel_by_set = ~v.row;
    id_first_frame = v.base + 12'd100;
    frame_num      = 16'd7;
    for (int k = 0; k < PE_NUM; k++) begin
      @(negedge clk);
      exp = make_entry(v.row, COL_W'(k), v.ids[k], '0, 1'b1);
      check_wr("f0_write", k, sb_wr_en, cur_entry(), exp);
    end
    @(negedge clk);
    check_int("f0_done_cycle", {done_score_board, busy, sb_wr_en}, 3'b110);
    // Start in the DONE cycle must be ignored.
    frame_num         = '0;
    start_score_board = 1'b1;
    @(posedge clk); #1;
    start_score_board = 1'b0;
    @(negedge clk);
    check_int("f0_after_done", {done_score_board, busy, sb_wr_en}, 3'b000);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [39:0] outs;
    int          wbase;
    int          dbase;

    f0_tbl[0].row = 4'd3;  f0_tbl[0].base = 12'd17;
    f0_tbl[0].ids = {12'd24, 12'd23, 12'd22, 12'd21, 12'd20, 12'd19, 12'd18, 12'd17};
    f0_tbl[1].row = 4'd9;  f0_tbl[1].base = 12'd4093;
    f0_tbl[1].ids = {12'd4, 12'd3, 12'd2, 12'd1, 12'd0, 12'd4095, 12'd4094, 12'd4093};
    f0_tbl[2].row = 4'd15; f0_tbl[2].base = 12'd0;
    f0_tbl[2].ids = {12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1, 12'd0};

    reset = 1'b1; start_score_board = 1'b0; frame_num = '0; row_sel_by_set = '0;
    id_first_frame = '0; cand_valid = 1'b0; cand_score = '0; cand_id = '0;
    cand_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    outs = {cand_ready, sb_wr_en, sb_wr_row, sb_wr_col, sb_wr_id, sb_wr_score,
            sb_wr_match, done_score_board, busy};
    check_int("reset_outputs_ones", $countones(outs), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) run_first(f0_tbl[i]);

    fill_pattern();
    run_collect("pattern", 4'd6, 1'b0, -1);

    fill_pattern();
    n_c[2] = 1; c_s[2][0] = 16'h0500; c_i[2][0] = 12'd7;
    n_c[5] = 1; c_s[5][0] = SCORE_ONES; c_i[5][0] = 12'd11;
    run_collect("nomatch", 4'd2, 1'b0, -1);

    fill_random();
    run_collect("rand_midstart", 4'd11, 1'b1, 3);
    for (int r = 0; r < 5; r++) begin
      fill_random();
      run_collect("rand", ROW_LEN'($urandom), r[0], -1);
    end

    // Reset while collecting PE 4 aborts the set without done or writes.
    fill_random();
    wbase = mon_q.size();
    dbase = done_cnt;
    frame_num = 16'd3; row_sel_by_set = 4'd9;
    pulse_start();
    feed_pes(0, 4, 1'b0, -1);
    send_cand(16'h0010, 12'd55, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    outs = {cand_ready, sb_wr_en, sb_wr_row, sb_wr_col, sb_wr_id, sb_wr_score,
            sb_wr_match, done_score_board, busy};
    check_int("abort_outputs_ones", $countones(outs), 0);
    repeat (20) begin @(posedge clk); #1; end
    check_int("abort_writes", mon_q.size() - wbase, 4);
    check_int("abort_done", done_cnt - dbase, 0);

    fill_random();
    run_collect("after_abort", 4'd1, 1'b1, -1);

    check_int("protocol_viol", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
